clk_div_strobe: RTL and testbench
=================================

// Module: clk_div_strobe
// PURPOSE
//  Consumes the free-running testbench/system clock and derives periodic single-cycle enable strobes
//  plus a divided square wave for slow peripherals, all in the clk domain (no new clock nets).
//  Divisor is reloadable at run time via a valid/ready handshake; changes take effect glitch-free at a period boundary.
// PARAMETERS
//  CNT_W        16  width of divisor and period counter
//  DIV_DEFAULT  4   divisor loaded at reset (1..2^CNT_W-1)
//  TCNT_W       32  width of the tick counter
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  en          in   1       run enable; 0 pauses the period counter
//  clr         in   1       synchronous restart: counter, phase and tick_count to 0
//  div_i       in   CNT_W   new divisor
//  div_valid   in   1       div_i valid
//  div_ready   out  1       block can accept a divisor
//  tick        out  1       one-cycle strobe every div cycles while running
//  clk_div_o   out  1       toggles on every tick (period 2*div cycles)
//  tick_count  out  TCNT_W  number of ticks issued, wraps
//  busy        out  1       1 in RUN state
// BEHAVIOUR
//  Reset: cnt=0, div_reg=DIV_DEFAULT, no pending, state IDLE; tick=0, clk_div_o=0, tick_count=0, div_ready=1, busy=0.
//  All outputs registered. Divisor 0 on div_i is clamped to 1.
//  FSM: IDLE -(en)-> RUN; RUN -(!en)-> HOLD; HOLD -(en)-> RUN; any state -(clr)-> IDLE; rst overrides all.
//   IDLE: cnt=0, tick=0. HOLD: cnt and clk_div_o frozen, tick=0.
//   RUN: cnt increments; at edge where cnt==div_reg-1: cnt<=0, tick<=1, clk_div_o<=~clk_div_o, tick_count<=+1.
//  Latency: en first sampled high at edge E -> first tick high in the cycle after edge E+div_reg;
//   subsequent ticks every div_reg cycles. div_reg==1 -> tick stays high continuously while RUN.
//  HOLD preserves phase: total RUN cycles between ticks is always div_reg.
//  Handshake: transfer on div_valid&&div_ready. Captured value goes to pending, div_ready<=0.
//   Pending is applied: immediately (next edge) in IDLE or HOLD; in RUN at the wrap edge, so the period
//   ending at that wrap uses the old divisor and the next uses the new. div_ready<=1 on the apply edge.
//   div_valid while !div_ready: ignored, value not captured.
//  Simultaneous events:
//   clr with wrap: clr wins, no tick, tick_count not incremented; pending divisor applied at that edge.
//   clr with handshake: value captured and applied at same edge (ends IDLE with new div_reg).
//   en falling at the wrap edge: tick still issued, then HOLD.
//  tick_count wraps 2^TCNT_W-1 -> 0 silently.
//  rst mid-operation: returns to reset values at next edge, pending divisor discarded.
// STRUCTURE
//  Package clk_div_pkg: state_t enum {IDLE, RUN, HOLD}, DIV_MIN=1, clamp function div_clamp().
//  Sub-module clk_div_counter: period counter with load/wrap/hold inputs, wrap output; FSM/handshake in top.
// TESTING
//  rst 3 cycles, en=1, div=4 -> tick high at cycles 4,8,12 after en sampled; clk_div_o period 8; tick_count=3.
//  div=1 -> tick constantly 1, tick_count increments every cycle; div_i=0 loaded -> behaves as div=1.
//  RUN div=4, load div=6 mid-period -> div_ready low until wrap, that period 4, next periods 6.
//  en low for 5 cycles at cnt=2, div=4 -> no tick during HOLD, next tick 2 RUN cycles after resume.
//  clr asserted on wrap edge -> no tick, tick_count unchanged, clk_div_o=0, state IDLE.
//  TCNT_W=4, run 17 ticks -> tick_count reads 1; rst during RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider strobe generator.
// The clamp keeps a zero divisor from ever reaching the period counter.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DIV_MIN = 1;
  localparam int CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] div_clamp(input logic [CLAMP_W-1:0] d);
    return (d == '0) ? CLAMP_W'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: counts advance cycles from 0 to div-1 and flags the wrap edge.
// load restarts from 0; deasserting advance holds the count (phase preserved).
module clk_div_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  // div is never 0 here, so div-1 cannot underflow.
  assign wrap = advance && (cnt == div - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_strobe.sv
// Divided strobe / square-wave generator with run-time reloadable divisor.
// Handshake: a divisor transfers on the edge where div_valid && div_ready; div_ready stays low until it is applied.
module clk_div_strobe
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 4,
  parameter int TCNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [CNT_W-1:0]  div_i,
  input  logic              div_valid,
  output logic              div_ready,
  output logic              tick,
  output logic              clk_div_o,
  output logic [TCNT_W-1:0] tick_count,
  output logic              busy,
  output state_t            state_dbg
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   div_reg, pend_val, div_new, cnt;
  logic [CLAMP_W-1:0] clamp_tmp;
  logic               wrap, hs, advance;

  assign hs        = div_valid && div_ready;
  assign advance   = (state_q == RUN) && !clr;
  assign state_dbg = state_q;

  always_comb begin
    clamp_tmp = div_clamp(CLAMP_W'(div_i));
  end
  assign div_new = clamp_tmp[CNT_W-1:0];

  clk_div_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (clr),
    .advance (advance),
    .div     (div_reg),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = HOLD;
      HOLD:    if (en)  state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg    <= CNT_W'(DIV_DEFAULT);
      pend_val   <= '0;
      div_ready  <= 1'b1;
      tick       <= 1'b0;
      clk_div_o  <= 1'b0;
      tick_count <= '0;
      busy       <= 1'b0;
    end else begin
      tick <= 1'b0;
      busy <= (state_d == RUN);
      if (clr) begin
        clk_div_o  <= 1'b0;
        tick_count <= '0;
        // A divisor offered or pending during clr lands directly in div_reg.
        if (hs) begin
          div_reg <= div_new;
        end else if (!div_ready) begin
          div_reg   <= pend_val;
          div_ready <= 1'b1;
        end
      end else begin
        if (wrap) begin
          tick       <= 1'b1;
          clk_div_o  <= ~clk_div_o;
          tick_count <= tick_count + TCNT_W'(1);
        end
        if (hs) begin
          pend_val  <= div_new;
          div_ready <= 1'b0;
        end else if (!div_ready && ((state_q != RUN) || wrap)) begin
          div_reg   <= pend_val;
          div_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_strobe.sv
// Bench for clk_div_strobe: a cycle-level model of period/phase arithmetic checked every cycle,
// plus directed literal expectations for latency, reload, hold, clr and wrap scenarios.
module tb_clk_div_strobe;
  import clk_div_pkg::*;

  localparam int CW   = 16;
  localparam int TW   = 4;
  localparam int DDEF = 4;
  localparam int TMOD = 1 << TW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en = 1'b0, clr = 1'b0, div_valid = 1'b0;
  logic [CW-1:0] div_i = '0;
  logic          div_ready, tick, clk_div_o, busy;
  logic [TW-1:0] tick_count;
  state_t        state_dbg;

  clk_div_strobe #(.CNT_W(CW), .DIV_DEFAULT(DDEF), .TCNT_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .div_i      (div_i),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .tick       (tick),
    .clk_div_o  (clk_div_o),
    .tick_count (tick_count),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=stopped, 1=running, 2=paused; phase counts running edges since last tick.
  int m_mode, m_phase, m_div, e_cnt;
  int m_pend_q[$];
  bit e_tick, e_clk, e_ready, e_busy, m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_phase = 0; m_div = DDEF; m_pend_q.delete();
      e_tick = 0; e_clk = 0; e_cnt = 0; e_ready = 1; e_busy = 0;
      m_valid = 1;
    end else if (m_valid) begin
      bit hs, wrapped;
      int nd;
      hs      = div_valid && e_ready;
      nd      = (div_i == 0) ? 1 : int'(div_i);
      wrapped = 0;
      e_tick  = 0;
      if (clr) begin
        if (hs) m_div = nd;
        else if (m_pend_q.size() > 0) m_div = m_pend_q.pop_front();
        e_ready = 1; m_mode = 0; m_phase = 0; e_clk = 0; e_cnt = 0;
      end else begin
        if (m_mode == 1) begin
          m_phase++;
          if (m_phase == m_div) begin
            wrapped = 1; m_phase = 0; e_tick = 1;
            e_clk = !e_clk; e_cnt = (e_cnt + 1) % TMOD;
          end
        end
        if (m_pend_q.size() > 0 && (m_mode != 1 || wrapped)) begin
          m_div = m_pend_q.pop_front(); e_ready = 1;
        end
        if (hs) begin
          m_pend_q.push_back(nd); e_ready = 0;
        end
        if (m_mode == 1) m_mode = en ? 1 : 2;
        else if (en)     m_mode = 1;
      end
      e_busy = (m_mode == 1);
    end
  end

  // scoreboard compare every cycle once the model has seen reset
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_tick",       32'(tick),       32'(e_tick));
      chk("m_clk_div_o",  32'(clk_div_o),  32'(e_clk));
      chk("m_tick_count", 32'(tick_count), 32'(e_cnt));
      chk("m_div_ready",  32'(div_ready),  32'(e_ready));
      chk("m_busy",       32'(busy),       32'(e_busy));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tick"},       32'(tick),       0);
    chk({tag, "_clk_div_o"},  32'(clk_div_o),  0);
    chk({tag, "_tick_count"}, 32'(tick_count), 0);
    chk({tag, "_div_ready"},  32'(div_ready),  1);
    chk({tag, "_busy"},       32'(busy),       0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [TW-1:0] prev;
    // reset 3 cycles
    repeat (3) step();
    check_reset_vals("rst");

    // div=4: ticks at 4, 8, 12 after en sampled
    rst = 1'b0; en = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("d4_tick", 32'(tick), (k % 4 == 0) ? 1 : 0);
      if (k == 4) chk("d4_clk_hi", 32'(clk_div_o), 1);
      if (k == 8) chk("d4_clk_lo", 32'(clk_div_o), 0);
    end
    chk("d4_tick_count", 32'(tick_count), 3);

    // hold: pause with count at 2, resume needs 2 more running edges
    step();
    en = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("hold_tick", 32'(tick), 0);
      chk("hold_busy", 32'(busy), 0);
    end
    en = 1'b1;
    step();
    step();
    chk("resume_tick1", 32'(tick), 0);
    step();
    chk("resume_tick2", 32'(tick), 1);

    // reload to 6 mid-run: current period stays 4, then 6
    div_i = 16'd6; div_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      div_valid = 1'b0;
      chk("rl_tick", 32'(tick), (k == 4 || k == 10 || k == 16) ? 1 : 0);
      chk("rl_ready", 32'(div_ready), (k < 4) ? 0 : 1);
    end

    // div_i=0 clamps to 1: continuous tick after the current 6-period
    div_i = 16'd0; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    repeat (5) step();
    chk("c1_first_tick", 32'(tick), 1);
    for (int k = 0; k < 8; k++) begin
      prev = tick_count;
      step();
      chk("c1_tick", 32'(tick), 1);
      chk("c1_inc", 32'(tick_count), 32'(TW'(prev + TW'(1))));
    end

    // clr on a wrap edge, then 17 ticks wraps a 4-bit tick_count to 1
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_tick", 32'(tick), 0);
    chk("clr_tick_count", 32'(tick_count), 0);
    chk("clr_clk_div_o", 32'(clk_div_o), 0);
    chk("clr_state", 32'(state_dbg), 32'(IDLE));
    step();
    repeat (16) step();
    chk("wrap16", 32'(tick_count), 0);
    step();
    chk("wrap17", 32'(tick_count), 1);

    // clr together with a handshake: divisor 4 applied at the clr edge
    clr = 1'b1; div_i = 16'd4; div_valid = 1'b1;
    step();
    clr = 1'b0; div_valid = 1'b0;
    chk("clrhs_ready", 32'(div_ready), 1);
    chk("clrhs_busy", 32'(busy), 0);
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("clrhs_tick", 32'(tick), (k == 4) ? 1 : 0);
    end

    // rst mid-run discards pending divisor 9
    div_i = 16'd9; div_valid = 1'b1;
    step();
    div_valid = 1'b0; rst = 1'b1;
    step();
    check_reset_vals("midrst");
    rst = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("postrst_tick", 32'(tick), (k == 4) ? 1 : 0);
    end

    // load in IDLE applies on the next edge
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; div_i = 16'd3; div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("idle_ready_lo", 32'(div_ready), 0);
    step();
    chk("idle_ready_hi", 32'(div_ready), 1);
    en = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("idle_d3_tick", 32'(tick), (k == 3) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
